// File: rtl/parking_slot_allocator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : parking_slot_allocator
// Description : Eight-slot parking lot allocator. An entry request is granted
//               the lowest free slot by scanning one slot per cycle. A full lot
//               returns a refusal. Exits free an occupied slot. An illegal
//               exit raises a one-cycle error.
// Revision    : 1.0 - initial release
// ============================================================================
module parking_slot_allocator #(
  parameter int NUM_SLOTS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enter_req,
  input  logic                 exit_req,
  input  logic [NUM_SLOTS-1:0] exit_location,
  output logic [NUM_SLOTS-1:0] park_location,
  output logic                 enter_ack,
  output logic                 enter_nack,
  output logic [NUM_SLOTS-1:0] parking_capacity,
  output logic [3:0]           free_count,
  output logic                 full,
  output logic                 exit_error
);

  localparam int PTR_W = $clog2(NUM_SLOTS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    GRANT  = 2'd2,
    REJECT = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PTR_W-1:0]     grant_q, grant_d;
  logic [NUM_SLOTS-1:0] cap_q, cap_d;
  logic                 exit_err_q, exit_err_d;
  logic [NUM_SLOTS-1:0] set_mask;
  logic [NUM_SLOTS-1:0] clr_mask;

  assign parking_capacity = cap_q;
  assign exit_error       = exit_err_q;
  assign full             = &cap_q;

  // Count vacant slots straight from the occupancy register.
  always_comb begin
    free_count = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!cap_q[i]) free_count = free_count + 4'd1;
    end
  end

  // Next-state, scan pointer, grant outputs and occupancy update.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_d       = grant_q;
    set_mask      = '0;
    clr_mask      = '0;
    exit_err_d    = 1'b0;
    enter_ack     = 1'b0;
    enter_nack    = 1'b0;
    park_location = '0;

    case (state_q)
      IDLE: begin
        if (enter_req) begin
          if (full) begin
            state_d = REJECT;
          end else begin
            state_d = SEARCH;
            ptr_d   = '0;
          end
        end
      end
      SEARCH: begin
        // Occupancy is read live, so a slot freed ahead of the pointer is found.
        if (!cap_q[ptr_q]) begin
          grant_d = ptr_q;
          state_d = GRANT;
        end else begin
          ptr_d = ptr_q + PTR_W'(1);
        end
      end
      GRANT: begin
        enter_ack              = 1'b1;
        park_location[grant_q] = 1'b1;
        set_mask               = park_location;
        state_d                = IDLE;
      end
      REJECT: begin
        enter_nack = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Exits are honoured in every state; only a one-hot hit on an occupied slot is legal.
    if (exit_req) begin
      if ($onehot(exit_location) && ((exit_location & cap_q) != '0)) begin
        clr_mask = exit_location;
      end else begin
        exit_err_d = 1'b1;
      end
    end

    // A granted slot is free, so a legal exit never targets the same bit.
    cap_d = (cap_q & ~clr_mask) | set_mask;
  end

  // State registers with synchronous reset dominating every input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      cap_q      <= '0;
      exit_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      cap_q      <= cap_d;
      exit_err_q <= exit_err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_parking_slot_allocator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_parking_slot_allocator
// Description : Directed self-checking bench for parking_slot_allocator with a
//               cycle-level transaction model and literal spot checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parking_slot_allocator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enter_req = 1'b0;
  logic       exit_req = 1'b0;
  logic [7:0] exit_location = 8'h00;
  logic [7:0] park_location;
  logic       enter_ack;
  logic       enter_nack;
  logic [7:0] parking_capacity;
  logic [3:0] free_count;
  logic       full;
  logic       exit_error;

  int n_vec = 0;
  int n_err = 0;

  parking_slot_allocator #(.NUM_SLOTS(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .enter_req        (enter_req),
    .exit_req         (exit_req),
    .exit_location    (exit_location),
    .park_location    (park_location),
    .enter_ack        (enter_ack),
    .enter_nack       (enter_nack),
    .parking_capacity (parking_capacity),
    .free_count       (free_count),
    .full             (full),
    .exit_error       (exit_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // m_age   : slot being examined by the pending entry (-1 when none pending)
  // m_gslot : slot being handed out this cycle (-1 when none)
  logic [7:0] m_cap;
  int         m_age = -1;
  int         m_gslot = -1;
  bit         m_nack = 1'b0;
  bit         m_err = 1'b0;
  bit         m_valid = 1'b0;
  logic [7:0] m_next;
  bit         m_idle;

  always @(posedge clk) begin
    if (rst) begin
      m_cap = 8'h00; m_age = -1; m_gslot = -1; m_nack = 1'b0; m_err = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_next = m_cap;
      if (m_gslot >= 0) m_next[m_gslot] = 1'b1;
      m_err = 1'b0;
      if (exit_req) begin
        if ($countones(exit_location) == 1 && (m_cap & exit_location) != 8'h00)
          m_next = m_next & ~exit_location;
        else
          m_err = 1'b1;
      end
      m_idle = (m_age < 0) && (m_gslot < 0) && !m_nack;
      if (m_idle) begin
        if (enter_req) begin
          if (m_cap == 8'hFF) m_nack = 1'b1;
          else                m_age  = 0;
        end
      end else if (m_age >= 0) begin
        if (m_age > 7)            m_age = -1;
        else if (!m_cap[m_age]) begin m_gslot = m_age; m_age = -1; end
        else                      m_age++;
      end else begin
        m_gslot = -1; m_nack = 1'b0;
      end
      m_cap = m_next;
    end
  end

  // Compare every output against the model each cycle.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_ack",  enter_ack,        (m_gslot >= 0));
      chk("m_loc",  park_location,    (m_gslot >= 0) ? (8'h01 << m_gslot) : 8'h00);
      chk("m_nack", enter_nack,       m_nack);
      chk("m_err",  exit_error,       m_err);
      chk("m_cap",  parking_capacity, m_cap);
      chk("m_free", free_count,       8 - $countones(m_cap));
      chk("m_full", full,             (m_cap == 8'hFF));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit er, input bit xr, input logic [7:0] xl);
    enter_req = er; exit_req = xr; exit_location = xl;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(0, 0, 8'h00);
    step(0, 0, 8'h00);
    rst = 1'b0;
  endtask

  // One-cycle request pulse; returns the cycle index of the ack/nack.
  task automatic run_req(output int lat);
    step(1, 0, 8'h00);
    lat = 1;
    while (!enter_ack && !enter_nack && lat < 20) begin
      step(0, 0, 8'h00);
      lat++;
    end
  endtask

  // Hold enter_req until the lot is full; counts grants.
  task automatic fill(output int acks);
    acks = 0;
    for (int i = 0; i < 200 && !full; i++) begin
      step(1, 0, 8'h00);
      if (enter_ack) acks++;
    end
    enter_req = 1'b0;
  endtask

  int lat;
  int acks;

  initial begin
    do_reset();
    chk("rst_cap",  parking_capacity, 8'h00);
    chk("rst_free", free_count, 4'd8);
    chk("rst_full", full, 1'b0);
    chk("rst_ack",  enter_ack, 1'b0);

    // First car into empty lot: slot 0, two cycles.
    run_req(lat);
    chk("t1_lat", lat, 2);
    chk("t1_loc", park_location, 8'h01);
    step(0, 0, 8'h00);
    chk("t1_cap",  parking_capacity, 8'h01);
    chk("t1_free", free_count, 4'd7);

    // Slot 1 then slot 2.
    run_req(lat);
    chk("t2a_lat", lat, 3);
    chk("t2a_loc", park_location, 8'h02);
    step(0, 0, 8'h00);
    chk("t2a_cap", parking_capacity, 8'h03);
    run_req(lat);
    chk("t2b_lat", lat, 4);
    chk("t2b_loc", park_location, 8'h04);
    step(0, 0, 8'h00);
    chk("t2b_cap", parking_capacity, 8'h07);

    // Eight back-to-back grants from empty, then a refused ninth.
    do_reset();
    fill(acks);
    chk("t3_acks", acks, 8);
    chk("t3_cap",  parking_capacity, 8'hFF);
    chk("t3_full", full, 1'b1);
    chk("t3_free", free_count, 4'd0);
    step(1, 0, 8'h00);
    chk("t3_nack", enter_nack, 1'b1);
    chk("t3_ack",  enter_ack, 1'b0);
    step(0, 0, 8'h00);
    chk("t3_nack_off", enter_nack, 1'b0);
    chk("t3_cap2", parking_capacity, 8'hFF);

    // Reduce to 8'h44, then illegal and legal exits.
    foreach (exit_location[i]) begin end
    for (int i = 0; i < 8; i++) begin
      if (i != 2 && i != 6) step(0, 1, 8'h01 << i);
    end
    chk("t4_cap", parking_capacity, 8'h44);
    step(0, 1, 8'h02);
    chk("t4_err1", exit_error, 1'b1);
    chk("t4_cap1", parking_capacity, 8'h44);
    step(0, 1, 8'h06);
    chk("t4_err2", exit_error, 1'b1);
    chk("t4_cap2", parking_capacity, 8'h44);
    step(0, 1, 8'h04);
    chk("t4_err3", exit_error, 1'b0);
    chk("t4_cap3", parking_capacity, 8'h40);
    step(0, 0, 8'h00);

    // Refill, free slot 0, then grant slot 0 while slot 4 exits.
    fill(acks);
    chk("t5_acks", acks, 7);
    step(0, 1, 8'h01);
    chk("t5_cap0", parking_capacity, 8'hFE);
    step(1, 0, 8'h00);
    step(0, 0, 8'h00);
    chk("t5_ack", enter_ack, 1'b1);
    chk("t5_loc", park_location, 8'h01);
    step(0, 1, 8'h10);
    chk("t5_cap", parking_capacity, 8'hEF);
    chk("t5_err", exit_error, 1'b0);

    // Slot freed ahead of the scan pointer is picked over slot 4.
    step(1, 0, 8'h00);
    step(0, 1, 8'h04);
    lat = 2;
    while (!enter_ack && lat < 20) begin
      step(0, 0, 8'h00);
      lat++;
    end
    chk("t6_lat", lat, 4);
    chk("t6_loc", park_location, 8'h04);
    step(0, 0, 8'h00);
    chk("t6_cap", parking_capacity, 8'hEF);

    // Reset in the middle of a scan.
    step(1, 0, 8'h00);
    step(0, 0, 8'h00);
    rst = 1'b1;
    step(0, 0, 8'h00);
    rst = 1'b0;
    chk("t7_cap", parking_capacity, 8'h00);
    chk("t7_ack", enter_ack, 1'b0);
    for (int i = 0; i < 4; i++) step(0, 0, 8'h00);

    // Reset during the grant cycle discards the grant.
    step(1, 0, 8'h00);
    step(0, 0, 8'h00);
    chk("t8_ack", enter_ack, 1'b1);
    rst = 1'b1;
    step(0, 0, 8'h00);
    rst = 1'b0;
    chk("t8_cap", parking_capacity, 8'h00);
    chk("t8_ack_off", enter_ack, 1'b0);
    step(0, 0, 8'h00);
    chk("t8_cap2", parking_capacity, 8'h00);
    step(0, 0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
